// File: rtl/qubit_measure.sv
// Two-qubit projective measurement: squares amplitudes into a CDF, then draws
// SHOTS outcomes with a 16-bit LFSR and accumulates a 4-bin histogram.
module qubit_measure #(
   parameter int          N     = 16,
   parameter int          FRAC  = 14,
   parameter int          SHOTS = 1024,
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          CW    = $clog2(SHOTS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  psi_in [0:7],
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] count [0:3],
   output logic          zero_state
);

   localparam int TW = 2 * N + 2;
   localparam logic [15:0] LAST = 16'(SHOTS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PROB   = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // 1.0 must fit as a positive signed amplitude
   if (FRAC > N - 2) begin : g_bad_frac
      $error("FRAC too large for N");
   end
   if (SEED == 16'h0000) begin : g_bad_seed
      $error("SEED must be nonzero");
   end

   logic [1:0]    r_state;
   logic [N-1:0]  r_psi [0:7];
   logic [1:0]    r_k;
   logic [TW-1:0] r_cdf [0:3];
   logic [15:0]   r_shot;
   logic [15:0]   r_lfsr;
   logic [CW-1:0] r_count [0:3];
   logic          r_zero;

   logic signed [N-1:0]   w_re;
   logic signed [N-1:0]   w_im;
   logic signed [2*N-1:0] w_sq_re;
   logic signed [2*N-1:0] w_sq_im;
   logic [2*N-1:0]        w_p;
   logic [TW-1:0]         w_prev;
   logic [TW-1:0]         w_cdf;
   logic [TW+15:0]        w_prod;
   logic [TW-1:0]         w_thr;
   logic [1:0]            w_out;
   logic [15:0]           w_lfsr_nxt;

   assign w_re    = $signed(r_psi[{r_k, 1'b0}]);
   assign w_im    = $signed(r_psi[{r_k, 1'b1}]);
   assign w_sq_re = w_re * w_re;
   assign w_sq_im = w_im * w_im;
   assign w_p     = $unsigned(w_sq_re) + $unsigned(w_sq_im);
   assign w_prev  = (r_k == 2'd0) ? '0 : r_cdf[r_k - 2'd1];
   assign w_cdf   = w_prev + TW'(w_p);

   // r_cdf[3] holds the total probability during SAMPLE
   assign w_prod = r_lfsr * r_cdf[3];
   assign w_thr  = w_prod[TW+15:16];

   always_comb begin
      w_out = 2'd3;
      if (w_thr < r_cdf[0])      w_out = 2'd0;
      else if (w_thr < r_cdf[1]) w_out = 2'd1;
      else if (w_thr < r_cdf[2]) w_out = 2'd2;
   end

   assign w_lfsr_nxt = {r_lfsr[14:0],
                        r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_lfsr  <= SEED;
         r_zero  <= 1'b0;
         r_k     <= 2'd0;
         r_shot  <= 16'd0;
         for (int i = 0; i < 4; i++) begin
            r_count[i] <= '0;
            r_cdf[i]   <= '0;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_psi   <= psi_in;
                  r_zero  <= 1'b0;
                  r_k     <= 2'd0;
                  r_state <= S_PROB;
                  for (int i = 0; i < 4; i++) r_count[i] <= '0;
               end
            end
            S_PROB: begin
               r_cdf[r_k] <= w_cdf;
               r_k        <= r_k + 2'd1;
               if (r_k == 2'd3) begin
                  r_shot <= 16'd0;
                  if (w_cdf == '0) begin
                     r_zero  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_SAMPLE;
                  end
               end
            end
            S_SAMPLE: begin
               r_count[w_out] <= r_count[w_out] + CW'(1);
               r_lfsr         <= w_lfsr_nxt;
               r_shot         <= r_shot + 16'd1;
               if (r_shot == LAST) r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_DONE);
   assign zero_state = r_zero;
   assign count      = r_count;

endmodule

// File: tb/tb_qubit_measure.sv
// Randomized bench for qubit_measure against a shot-by-shot sampling model.
module tb_qubit_measure;

   localparam int          N     = 16;
   localparam int          SHOTS = 1024;
   localparam int          CW    = $clog2(SHOTS + 1);
   localparam logic [15:0] SEED  = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  psi_in [0:7];
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count [0:3];
   logic          zero_state;

   qubit_measure #(.N(N), .FRAC(14), .SHOTS(SHOTS), .SEED(SEED)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .psi_in     (psi_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .zero_state (zero_state)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] m_lfsr;
   logic [15:0] cur [0:7];
   int          exp_cnt [4];
   int          first_cnt [4];
   bit          exp_zero;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inverse-CDF sampling straight from the amplitude definitions
   task automatic model_job();
      longint cdf [4];
      longint acc = 0;
      longint thr;
      longint re, im;
      int     k;
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      for (int b = 0; b < 4; b++) begin
         re = longint'($signed(cur[2*b]));
         im = longint'($signed(cur[2*b+1]));
         acc += re * re + im * im;
         cdf[b] = acc;
      end
      exp_zero = (acc == 0);
      if (!exp_zero) begin
         for (int s = 0; s < SHOTS; s++) begin
            thr = (longint'(m_lfsr) * acc) >> 16;
            k = 0;
            while (k < 3 && thr >= cdf[k]) k++;
            exp_cnt[k]++;
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
         end
      end
   endtask

   task automatic run_job(input bit hold_iv, input int bp);
      int n;
      int sum;
      for (int i = 0; i < 8; i++) psi_in[i] = cur[i];
      in_valid = 1'b1;
      chk("ready_idle", in_ready, 1);
      @(posedge clk);
      #1;
      model_job();
      if (!hold_iv) in_valid = 1'b0;
      chk("ready_busy", in_ready, 0);
      n = 0;
      while (!out_valid && n < SHOTS + 50) begin
         if (hold_iv) for (int i = 0; i < 8; i++) psi_in[i] = 16'($urandom);
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("latency", n, exp_zero ? 4 : 4 + SHOTS);
      chk("zero_state", zero_state, exp_zero);
      sum = 0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("count%0d", k), count[k], exp_cnt[k]);
         sum += int'(count[k]);
      end
      chk("count_sum", sum, exp_zero ? 0 : SHOTS);
      for (int c = 0; c < bp; c++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_ready", in_ready, 0);
         for (int k = 0; k < 4; k++)
            chk($sformatf("bp_count%0d", k), count[k], exp_cnt[k]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("pop_valid", out_valid, 0);
      chk("pop_ready", in_ready, 1);
   endtask

   task automatic set_state(input logic [15:0] v [0:7]);
      for (int i = 0; i < 8; i++) cur[i] = v[i];
   endtask

   logic [15:0] st [0:7];

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) psi_in[i] = '0;
      m_lfsr = SEED;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_zero", zero_state, 0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_count%0d", k), count[k], 0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) st[i] = (i % 2 == 0) ? 16'h2000 : 16'h0000;
      set_state(st);
      run_job(1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         first_cnt[k] = exp_cnt[k];
         chk($sformatf("eq_range%0d", k),
             (count[k] >= 192 && count[k] <= 320) ? 1 : 0, 1);
      end

      for (int i = 0; i < 8; i++) st[i] = '0;
      st[0] = 16'h4000;
      set_state(st);
      run_job(1'b0, 0);
      chk("ket00", count[0], SHOTS);

      for (int i = 0; i < 8; i++) st[i] = '0;
      st[7] = 16'hC000;
      set_state(st);
      run_job(1'b1, 0);
      chk("ket11", count[3], SHOTS);

      for (int i = 0; i < 8; i++) st[i] = '0;
      set_state(st);
      run_job(1'b0, 0);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) st[i] = 16'($urandom);
         set_state(st);
         run_job(1'b0, (r == 0) ? 20 : 0);
      end

      for (int i = 0; i < 8; i++) st[i] = (i % 2 == 0) ? 16'h2000 : 16'h0000;
      set_state(st);
      for (int i = 0; i < 8; i++) psi_in[i] = cur[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (104) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 1);
      for (int k = 0; k < 4; k++) chk($sformatf("abort_count%0d", k), count[k], 0);
      rst_n  = 1'b1;
      m_lfsr = SEED;
      run_job(1'b0, 0);
      for (int k = 0; k < 4; k++) chk($sformatf("rerun%0d", k), count[k], first_cnt[k]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
